// File: rtl/kp_stream_scheduler.sv
// Buffers the sparse FAST keypoint stream per frame, enforces the keypoint budget and score gate,
// and hands records downstream over valid/ready, closing each frame with one end-of-frame marker.
module kp_stream_scheduler #(
  parameter int          DEPTH     = 64,
  parameter int          MAX_KP    = 500,
  parameter logic [7:0]  MIN_SCORE = 8'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_end,
  input  logic        i_flag,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic [7:0]  i_score,
  input  logic [11:0] i_cos,
  input  logic [11:0] i_sin,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [51:0] o_data,
  output logic        o_last,
  output logic [9:0]  o_kp_count,
  output logic [15:0] o_drop_count,
  output logic        o_busy
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [9:0] KP_LIMIT = 10'(MAX_KP);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_MARK    = 2'd3;

  logic [1:0]  state;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [51:0] mem [DEPTH];
  logic [9:0]  kp_count;
  logic [15:0] drop_count;

  logic fifo_empty;
  logic fifo_full;
  logic fifo_valid;
  logic score_ok;
  logic kp_event;
  logic push;
  logic drop;
  logic pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_valid = !fifo_empty && ((state == S_COLLECT) || (state == S_DRAIN));

  // The constant leading 1 keeps the compare meaningful even when MIN_SCORE is zero.
  assign score_ok = ({1'b1, i_score} >= {1'b1, MIN_SCORE});
  assign kp_event = (state == S_COLLECT) && i_flag && score_ok;
  assign push     = kp_event && (kp_count < KP_LIMIT) && !fifo_full;
  assign drop     = kp_event && !push;
  assign pop      = fifo_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {i_x, i_y, i_score, i_cos, i_sin};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      kp_count   <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_COLLECT;
            kp_count   <= '0;
            drop_count <= '0;
          end
        end
        S_COLLECT: begin
          if (push) kp_count <= kp_count + 10'd1;
          if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
          if (i_end) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_empty) state <= S_MARK;
        end
        S_MARK: begin
          if (i_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stale RAM contents are masked so o_data reads zero whenever no keypoint is presented.
  assign o_valid      = fifo_valid || (state == S_MARK);
  assign o_last       = (state == S_MARK);
  assign o_data       = fifo_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign o_kp_count   = kp_count;
  assign o_drop_count = drop_count;
  assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_kp_stream_scheduler.sv
// Directed bench for kp_stream_scheduler built with DEPTH=4, MAX_KP=5, MIN_SCORE=20 so the
// FIFO-full, budget and score-gate boundaries are all reachable in short frames.
module tb_kp_stream_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_end;
  logic        i_flag;
  logic [9:0]  i_x;
  logic [9:0]  i_y;
  logic [7:0]  i_score;
  logic [11:0] i_cos;
  logic [11:0] i_sin;
  logic        i_ready;
  logic        o_valid;
  logic [51:0] o_data;
  logic        o_last;
  logic [9:0]  o_kp_count;
  logic [15:0] o_drop_count;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  kp_stream_scheduler #(
    .DEPTH(4),
    .MAX_KP(5),
    .MIN_SCORE(8'd20)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_end(i_end),
    .i_flag(i_flag),
    .i_x(i_x),
    .i_y(i_y),
    .i_score(i_score),
    .i_cos(i_cos),
    .i_sin(i_sin),
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_last(o_last),
    .o_kp_count(o_kp_count),
    .o_drop_count(o_drop_count),
    .o_busy(o_busy)
  );

  function automatic logic [51:0] mk(input logic [9:0] x, input logic [9:0] y,
                                     input logic [7:0] s, input logic [11:0] c,
                                     input logic [11:0] sn);
    return {x, y, s, c, sn};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_start = 1'b0;
    i_end   = 1'b0;
    i_flag  = 1'b0;
    i_x     = '0;
    i_y     = '0;
    i_score = '0;
    i_cos   = '0;
    i_sin   = '0;
  endtask

  task automatic apply_stimulus(input logic [51:0] r, input logic last_px);
    i_flag = 1'b1;
    {i_x, i_y, i_score, i_cos, i_sin} = r;
    i_end = last_px;
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Waits (bounded) for a record, checks it, then lets the next edge consume it (i_ready assumed 1).
  task automatic expect_rec(input string tag, input logic [51:0] r, input logic last);
    int w = 0;
    while (!o_valid && w < 20) begin
      step();
      w++;
    end
    check_output({tag, "_valid"}, 64'(o_valid), 64'd1);
    check_output({tag, "_data"},  64'(o_data),  64'(r));
    check_output({tag, "_last"},  64'(o_last),  64'(last));
    step();
  endtask

  logic [51:0] ra, rb, rc;
  int valid_seen;

  initial begin
    ra = mk(10'd40,  10'd35,  8'd50, 12'h111, 12'h0A1);
    rb = mk(10'd41,  10'd35,  8'd60, 12'h222, 12'h0B2);
    rc = mk(10'd100, 10'd200, 8'd30, 12'h333, 12'h0C3);

    i_rst_n = 1'b0;
    i_ready = 1'b0;
    idle_inputs();
    step();
    step();
    check_output("rst_valid", 64'(o_valid), 64'd0);
    check_output("rst_last",  64'(o_last),  64'd0);
    check_output("rst_busy",  64'(o_busy),  64'd0);
    check_output("rst_data",  64'(o_data),  64'd0);
    check_output("rst_kp",    64'(o_kp_count),   64'd0);
    check_output("rst_drop",  64'(o_drop_count), 64'd0);
    i_rst_n = 1'b1;
    step();

    $display("[TB] frame 1: three keypoints, ready held high");
    i_ready = 1'b1;
    start_frame();
    check_output("f1_busy", 64'(o_busy), 64'd1);
    apply_stimulus(ra, 1'b0);
    step();
    check_output("f1_valid0", 64'(o_valid), 64'd1);
    check_output("f1_data0",  64'(o_data),  64'(ra));
    apply_stimulus(rb, 1'b0);
    step();
    check_output("f1_data1", 64'(o_data), 64'(rb));
    apply_stimulus(rc, 1'b1);
    step();
    check_output("f1_data2", 64'(o_data), 64'(rc));
    check_output("f1_last2", 64'(o_last), 64'd0);
    check_output("f1_kp",    64'(o_kp_count), 64'd3);
    idle_inputs();
    step();
    check_output("f1_drain_empty", 64'(o_valid), 64'd0);
    step();
    check_output("f1_mark_valid", 64'(o_valid), 64'd1);
    check_output("f1_mark_last",  64'(o_last),  64'd1);
    check_output("f1_mark_data",  64'(o_data),  64'd0);
    check_output("f1_mark_drop",  64'(o_drop_count), 64'd0);
    step();
    check_output("f1_idle_busy", 64'(o_busy), 64'd0);
    check_output("f1_held_kp",   64'(o_kp_count), 64'd3);
    apply_stimulus(ra, 1'b0);
    step();
    idle_inputs();
    check_output("idle_flag_valid", 64'(o_valid), 64'd0);
    check_output("idle_flag_kp",    64'(o_kp_count), 64'd3);

    $display("[TB] frame 2: downstream stall");
    i_ready = 1'b0;
    start_frame();
    apply_stimulus(ra, 1'b0);
    step();
    apply_stimulus(rb, 1'b0);
    step();
    apply_stimulus(rc, 1'b1);
    step();
    idle_inputs();
    for (int j = 0; j < 20; j++) begin
      check_output($sformatf("f2_hold%0d", j), 64'(o_data), 64'(ra));
      step();
    end
    check_output("f2_hold_valid", 64'(o_valid), 64'd1);
    check_output("f2_kp", 64'(o_kp_count), 64'd3);
    i_ready = 1'b1;
    expect_rec("f2_r0", ra, 1'b0);
    expect_rec("f2_r1", rb, 1'b0);
    expect_rec("f2_r2", rc, 1'b0);
    expect_rec("f2_mark", '0, 1'b1);
    check_output("f2_idle", 64'(o_busy), 64'd0);

    $display("[TB] frame 3: FIFO overflow with ready low");
    i_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(mk(10'(i), 10'd7, 8'(100 + i), 12'(i), 12'(i + 1)), (i == 9));
      step();
    end
    idle_inputs();
    check_output("f3_kp",    64'(o_kp_count),   64'd4);
    check_output("f3_drop",  64'(o_drop_count), 64'd6);
    check_output("f3_valid", 64'(o_valid),      64'd1);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_rec($sformatf("f3_r%0d", i), mk(10'(i), 10'd7, 8'(100 + i), 12'(i), 12'(i + 1)), 1'b0);
    end
    expect_rec("f3_mark", '0, 1'b1);
    check_output("f3_held_drop", 64'(o_drop_count), 64'd6);

    $display("[TB] frame 4: keypoint budget");
    start_frame();
    for (int i = 0; i < 9; i++) begin
      if (i >= 1) begin
        check_output($sformatf("f4_valid%0d", i), 64'(o_valid), 64'(i <= 5));
        if (i <= 5)
          check_output($sformatf("f4_data%0d", i), 64'(o_data),
                       64'(mk(10'(200 + i - 1), 10'd9, 8'd40, 12'h0F0, 12'(i - 1))));
      end
      if (i < 8) apply_stimulus(mk(10'(200 + i), 10'd9, 8'd40, 12'h0F0, 12'(i)), (i == 7));
      else       idle_inputs();
      step();
    end
    check_output("f4_kp",   64'(o_kp_count),   64'd5);
    check_output("f4_drop", 64'(o_drop_count), 64'd3);
    expect_rec("f4_mark", '0, 1'b1);

    $display("[TB] frame 5: score gate and keypoint on the end cycle");
    i_ready = 1'b0;
    start_frame();
    apply_stimulus(mk(10'd1, 10'd1, 8'd10, 12'h001, 12'h001), 1'b0);
    step();
    apply_stimulus(mk(10'd2, 10'd2, 8'd19, 12'h002, 12'h002), 1'b0);
    step();
    apply_stimulus(mk(10'd3, 10'd3, 8'd20, 12'h003, 12'h003), 1'b0);
    step();
    apply_stimulus(mk(10'd4, 10'd4, 8'd25, 12'h004, 12'h004), 1'b1);
    step();
    idle_inputs();
    check_output("f5_kp",   64'(o_kp_count),   64'd2);
    check_output("f5_drop", 64'(o_drop_count), 64'd0);
    i_ready = 1'b1;
    expect_rec("f5_s20", mk(10'd3, 10'd3, 8'd20, 12'h003, 12'h003), 1'b0);
    expect_rec("f5_s25", mk(10'd4, 10'd4, 8'd25, 12'h004, 12'h004), 1'b0);
    expect_rec("f5_mark", '0, 1'b1);

    $display("[TB] frame 6: stray start, then reset mid-frame");
    i_ready = 1'b0;
    start_frame();
    apply_stimulus(ra, 1'b0);
    step();
    apply_stimulus(rb, 1'b0);
    step();
    idle_inputs();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check_output("f6_start_kp",   64'(o_kp_count),   64'd2);
    check_output("f6_start_drop", 64'(o_drop_count), 64'd0);
    check_output("f6_start_data", 64'(o_data),       64'(ra));
    apply_stimulus(rc, 1'b0);
    step();
    idle_inputs();
    check_output("f6_kp3", 64'(o_kp_count), 64'd3);
    #2 i_rst_n = 1'b0;
    #1;
    check_output("f6_rst_valid", 64'(o_valid),      64'd0);
    check_output("f6_rst_kp",    64'(o_kp_count),   64'd0);
    check_output("f6_rst_drop",  64'(o_drop_count), 64'd0);
    check_output("f6_rst_busy",  64'(o_busy),       64'd0);
    step();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    valid_seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_valid) valid_seen++;
    end
    check_output("f6_no_marker", 64'(valid_seen), 64'd0);
    check_output("f6_idle_busy", 64'(o_busy),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kp_stream_scheduler.md
Name: kp_stream_scheduler

Overview:
- Sits between the FAST keypoint detector output and the downstream descriptor/matcher stage.
- Captures the sparse per-pixel keypoint stream (flag, coordinates, score, cos/sin) into a FIFO and applies a per-frame keypoint budget and a minimum-score gate.
- Hands records to the downstream stage over a valid/ready handshake, then closes each frame with an end-of-frame marker record.

Parameters:
DEPTH, 64, FIFO entries; power of 2, minimum 4
MAX_KP, 500, max keypoints accepted per frame; 1..1023
MIN_SCORE, 8'd0, keypoint accepted only if i_score >= MIN_SCORE

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  frame-start pulse from detector
i_end  input  1  frame-end pulse from detector (last pixel cycle)
i_flag  input  1  keypoint present this cycle
i_x  input  10  keypoint X
i_y  input  10  keypoint Y
i_score  input  8  keypoint score
i_cos  input  12  orientation cos
i_sin  input  12  orientation sin
i_ready  input  1  downstream accepts record
o_valid  output  1  record available
o_data  output  52  {x[51:42], y[41:32], score[31:24], cos[23:12], sin[11:0]}
o_last  output  1  current record is end-of-frame marker
o_kp_count  output  10  keypoints accepted this frame
o_drop_count  output  16  keypoints dropped this frame, saturating at 65535
o_busy  output  1  high in any state except S_IDLE

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- Reset values: all outputs 0; FIFO empty; state S_IDLE.
- Reset mid-frame discards all FIFO contents and the frame in progress.
- FSM states:
  - S_IDLE: i_start -> S_COLLECT; clears o_kp_count and o_drop_count in the same edge.
  - S_COLLECT: on i_end -> S_DRAIN.
  - S_DRAIN: when FIFO is empty -> S_MARK.
  - S_MARK: o_valid=1, o_last=1, o_data=0; on i_ready -> S_IDLE.
- i_start in any state other than S_IDLE is ignored.
- i_flag, i_end and the keypoint inputs are ignored outside S_COLLECT, except for the i_end cycle itself.
- Acceptance: a keypoint is evaluated on every cycle with i_flag=1 in S_COLLECT, including the cycle where i_end=1.
  - It is pushed only if i_score >= MIN_SCORE, o_kp_count < MAX_KP, and the FIFO is not full.
  - Score below MIN_SCORE: silently ignored; not counted as a drop.
  - Budget reached or FIFO full: o_drop_count increments, saturating at 65535.
- Full check uses the occupancy before the edge. A push while full is dropped even if a pop occurs on the same cycle.
- Simultaneous push and pop when not full: both happen; occupancy is unchanged.
- FIFO output:
  - First-word fall-through, registered write.
  - A keypoint pushed at edge t gives o_valid=1 from cycle t+1 if the FIFO was empty.
  - o_valid = FIFO not empty, in S_COLLECT or S_DRAIN.
  - Pop occurs when o_valid && i_ready.
  - o_data must stay stable while o_valid && !i_ready.
  - o_last=0 for keypoint records.
- Marker record:
  - Issued only after all keypoint records are popped.
  - Exactly one marker per frame.
  - o_kp_count and o_drop_count stay valid and held until the next i_start is accepted in S_IDLE.
- Pointers: log2(DEPTH)+1 bits; wrap-around via the MSB for full/empty.

Test Plan:
- Frame with flags at (40,35,s=50), (41,35,s=60), (100,200,s=30), i_ready=1 -> three records in order, then marker with o_last=1; o_kp_count=3, o_drop_count=0.
- Same frame with i_ready=0 for 20 cycles after the first push -> o_data holds {40,35,50,..} stable; after release all records drain in order, then the marker.
- DEPTH=4, 10 consecutive flags, i_ready=0 -> 4 stored, o_drop_count=6; release gives 4 records then the marker.
- MAX_KP=5, 8 flags, i_ready=1 -> 5 records, o_kp_count=5, o_drop_count=3.
- MIN_SCORE=20, scores 10,25 -> only the score-25 record; o_drop_count=0. Flag with i_end in the same cycle -> that keypoint is recorded before the marker.
- i_start pulse mid-collect -> ignored and counts unchanged. Reset asserted with 3 records queued -> o_valid=0 and counts=0 immediately; no marker is emitted.
